// File: rtl/ar_pkg.sv
// Shared definitions for the burst address register: FSM state encoding and load-source selects.
package ar_pkg;

    typedef enum logic [1:0] {
        AR_IDLE = 2'd0,
        AR_RUN  = 2'd1,
        AR_DONE = 2'd2
    } ar_state_e;

    localparam logic AR_SEL_IOUT = 1'b1;
    localparam logic AR_SEL_BUS  = 1'b0;

endpackage : ar_pkg

// File: rtl/ar_wrap_add.sv
// Combinational a + step with wrap flag; AR_LIMIT_WRAP_EN selects limit-window wrap instead of 2**WIDTH wrap.
module ar_wrap_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] step,
`ifdef AR_LIMIT_WRAP_EN
    input  logic [WIDTH-1:0] limit,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             wrap
);

    logic [WIDTH:0] sum_full;
`ifdef AR_LIMIT_WRAP_EN
    logic [WIDTH:0] sum_fold;
`endif

    always_comb begin
        sum_full = {1'b0, a} + {1'b0, step};
`ifdef AR_LIMIT_WRAP_EN
        // Fold back into the 0-based window [0..limit].
        sum_fold = sum_full - {1'b0, limit} - {{WIDTH{1'b0}}, 1'b1};
        if (sum_full > {1'b0, limit}) begin
            sum  = sum_fold[WIDTH-1:0];
            wrap = 1'b1;
        end else begin
            sum  = sum_full[WIDTH-1:0];
            wrap = 1'b0;
        end
`else
        sum  = sum_full[WIDTH-1:0];
        wrap = sum_full[WIDTH];
`endif
    end

endmodule : ar_wrap_add

// File: rtl/ar_burst_agu.sv
// Per-core address register with NCORES-strided burst generation; state updates on the falling clock edge.
// Optional AR_LIMIT_WRAP_EN adds the limit port and wraps addresses into [0..limit].
module ar_burst_agu
    import ar_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NCORES = 4,
    parameter int LEN_W  = 4,
    localparam int CID_W = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             WEN,
    input  logic             selAR,
    input  logic [WIDTH-1:0] IOut,
    input  logic [WIDTH-1:0] BusOut,
    input  logic [CID_W-1:0] coreID,
    input  logic             coreINC_AR,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             mem_ready,
`ifdef AR_LIMIT_WRAP_EN
    input  logic [WIDTH-1:0] limit,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             addr_valid,
    output logic             busy,
    output logic             done,
    output logic             wrapped
);

    ar_state_e        state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;

    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] add_sum;
    logic             add_wrap;

    // One adder serves both the lane offset (IDLE) and the burst stride (RUN).
    assign step = (state_q == AR_RUN) ? WIDTH'(NCORES) : WIDTH'(coreID);

    ar_wrap_add #(.WIDTH(WIDTH)) u_add (
        .a     (dout_q),
        .step  (step),
`ifdef AR_LIMIT_WRAP_EN
        .limit (limit),
`endif
        .sum   (add_sum),
        .wrap  (add_wrap)
    );

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= AR_IDLE;
            dout_q    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (WEN) begin
            dout_d    = (selAR == AR_SEL_IOUT) ? IOut : BusOut;
            wrapped_d = 1'b0;
            count_d   = '0;
            state_d   = AR_IDLE;
        end else begin
            unique case (state_q)
                AR_IDLE: begin
                    if (coreINC_AR) begin
                        dout_d    = add_sum;
                        wrapped_d = wrapped_q | add_wrap;
                    end
                    if (burst_start) begin
                        if (burst_len != '0) begin
                            state_d = AR_RUN;
                            count_d = burst_len;
                        end else begin
                            state_d = AR_DONE;
                        end
                    end
                end
                AR_RUN: begin
                    if (mem_ready) begin
                        dout_d    = add_sum;
                        wrapped_d = wrapped_q | add_wrap;
                        count_d   = count_q - 1'b1;
                        if (count_q == LEN_W'(1)) begin
                            state_d = AR_DONE;
                        end
                    end
                end
                AR_DONE: state_d = AR_IDLE;
                default: state_d = AR_IDLE;
            endcase
        end
    end

    always_comb begin
        dout       = dout_q;
        wrapped    = wrapped_q;
        busy       = (state_q == AR_RUN);
        addr_valid = (state_q == AR_RUN);
        done       = (state_q == AR_DONE);
    end

endmodule : ar_burst_agu

// File: tb/tb_ar_burst_agu.sv
// Directed bench for ar_burst_agu (WIDTH=8, NCORES=4, LEN_W=4); define AR_LIMIT_WRAP_EN for the limit-wrap build.
module tb_ar_burst_agu;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       WEN, selAR, coreINC_AR, burst_start, mem_ready;
    logic [7:0] IOut, BusOut;
    logic [1:0] coreID;
    logic [3:0] burst_len;
`ifdef AR_LIMIT_WRAP_EN
    logic [7:0] limit;
`endif
    logic [7:0] dout;
    logic       addr_valid, busy, done, wrapped;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ar_burst_agu #(.WIDTH(8), .NCORES(4), .LEN_W(4)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .WEN         (WEN),
        .selAR       (selAR),
        .IOut        (IOut),
        .BusOut      (BusOut),
        .coreID      (coreID),
        .coreINC_AR  (coreINC_AR),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .mem_ready   (mem_ready),
`ifdef AR_LIMIT_WRAP_EN
        .limit       (limit),
`endif
        .dout        (dout),
        .addr_valid  (addr_valid),
        .busy        (busy),
        .done        (done),
        .wrapped     (wrapped)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next falling (active) edge and settle.
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [7:0] d, input logic av,
                               input logic bz, input logic dn, input logic wr);
        check({tag, ".dout"}, dout, d);
        check({tag, ".valid"}, addr_valid, av);
        check({tag, ".busy"}, busy, bz);
        check({tag, ".done"}, done, dn);
        check({tag, ".wrapped"}, wrapped, wr);
    endtask

    task automatic load(input logic [7:0] v);
        WEN = 1'b1; selAR = 1'b1; IOut = v;
        tick();
        WEN = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; WEN = 0; selAR = 0; coreINC_AR = 0; burst_start = 0; mem_ready = 0;
        IOut = '0; BusOut = '0; coreID = '0; burst_len = '0;
`ifdef AR_LIMIT_WRAP_EN
        limit = 8'h3F;
`endif
        tick(); tick();
        Rst_n = 1'b1;
        check_flags("rst", 8'h00, 0, 0, 0, 0);
        tick(); tick(); tick();
        check_flags("rst_idle", 8'h00, 0, 0, 0, 0);

        // Asynchronous reset mid-burst
        load(8'h55);
        check("pre_rst.dout", dout, 8'h55);
        burst_start = 1; burst_len = 4'd2; mem_ready = 0;
        tick();
        burst_start = 0;
        check("pre_rst.busy", busy, 1'b1);
        #2 Rst_n = 1'b0;
        #1 check_flags("async_rst", 8'h00, 0, 0, 0, 0);
        Rst_n = 1'b1;
        tick(); tick(); tick();
        check_flags("post_rst", 8'h00, 0, 0, 0, 0);

        // Load / offset
        load(8'h10);
        check("load_iout", dout, 8'h10);
        coreINC_AR = 1; coreID = 2'd3;
        tick();
        coreINC_AR = 0;
        check_flags("core_inc", 8'h13, 0, 0, 0, 0);
        WEN = 1; selAR = 0; BusOut = 8'h40; coreINC_AR = 1;
        tick();
        WEN = 0; coreINC_AR = 0;
        check("wen_over_inc", dout, 8'h40);

        // Three-beat burst
        load(8'h13);
        burst_start = 1; burst_len = 4'd3; mem_ready = 1;
        tick();
        burst_start = 0;
        check_flags("beat0", 8'h13, 1, 1, 0, 0);
        tick();
        check_flags("beat1", 8'h17, 1, 1, 0, 0);
        tick();
        check_flags("beat2", 8'h1B, 1, 1, 0, 0);
        tick();
        check_flags("burst_done", 8'h1F, 0, 0, 1, 0);
        tick();
        check_flags("after_done", 8'h1F, 0, 0, 0, 0);

        // Zero-length burst: straight to DONE, no beats
        burst_start = 1; burst_len = 4'd0;
        tick();
        burst_start = 0;
        check_flags("len0_done", 8'h1F, 0, 0, 1, 0);
        tick();
        check_flags("len0_idle", 8'h1F, 0, 0, 0, 0);

        // Stall then abort
        load(8'h20);
        burst_start = 1; burst_len = 4'd4; mem_ready = 1;
        tick();
        burst_start = 0;
        check_flags("s_beat0", 8'h20, 1, 1, 0, 0);
        tick();
        mem_ready = 0;
        check("s_beat1", dout, 8'h24);
        tick();
        check_flags("stall1", 8'h24, 1, 1, 0, 0);
        tick();
        check_flags("stall2", 8'h24, 1, 1, 0, 0);
        mem_ready = 1; WEN = 1; selAR = 1; IOut = 8'h80;
        tick();
        WEN = 0;
        check_flags("abort", 8'h80, 0, 0, 0, 0);
        tick();
        check_flags("abort_nodone", 8'h80, 0, 0, 0, 0);

`ifndef AR_LIMIT_WRAP_EN
        load(8'hFE);
        burst_start = 1; burst_len = 4'd1; mem_ready = 1;
        tick();
        burst_start = 0;
        check_flags("w_beat0", 8'hFE, 1, 1, 0, 0);
        tick();
        check_flags("w_done", 8'h02, 0, 0, 1, 1);
        tick();
        check("w_sticky", wrapped, 1'b1);
        load(8'h30);
        check_flags("w_clear", 8'h30, 0, 0, 0, 0);
`else
        load(8'h3E);
        burst_start = 1; burst_len = 4'd2; mem_ready = 1;
        tick();
        burst_start = 0;
        check_flags("l_beat0", 8'h3E, 1, 1, 0, 0);
        tick();
        check_flags("l_beat1", 8'h02, 1, 1, 0, 1);
        tick();
        check_flags("l_done", 8'h06, 0, 0, 1, 1);
        load(8'h30);
        check("l_clear", wrapped, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ar_burst_agu
